// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the control pipeline.
//   - control-word field offsets for the decoder's 32-bit word
//   - ALU select encodings
//   - EX-stage FSM state type and the per-stage register structs
//   - reg_hit(): one source-vs-destination RAW comparison
package cpu_pkg;

  localparam int CW_RS_HI    = 26;
  localparam int CW_RS_LO    = 22;
  localparam int CW_RT_HI    = 21;
  localparam int CW_RT_LO    = 17;
  localparam int CW_RD_HI    = 16;
  localparam int CW_RD_LO    = 12;
  localparam int CW_DSEL     = 11;
  localparam int CW_CSEL     = 10;
  localparam int CW_ALU_HI   = 9;
  localparam int CW_ALU_LO   = 8;
  localparam int CW_WRRD     = 7;
  localparam int CW_WBSEL    = 6;
  localparam int CW_WBEN     = 5;
  localparam int CW_WBREG_HI = 4;
  localparam int CW_WBREG_LO = 0;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic {EX_RUN = 1'b0, EX_MUL = 1'b1} ex_state_t;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       d_sel;
    logic       c_sel;
    logic [1:0] alu_sel;
    logic       wr_rd;
    logic       wb_sel;
    logic       wb_en;
    logic [4:0] wb_reg;
  } ex_stage_t;

  typedef struct packed {
    logic       wr_rd;
    logic       wb_sel;
    logic       wb_en;
    logic [4:0] wb_reg;
  } mem_stage_t;

  typedef struct packed {
    logic       wb_sel;
    logic       wb_en;
    logic [4:0] wb_reg;
  } wb_stage_t;

  // r0 is hard-wired, so it never carries a dependency.
  function automatic logic reg_hit(input logic used, input logic [4:0] src,
                                   input logic dst_valid, input logic dst_en,
                                   input logic [4:0] dst);
    return used && (src != 5'd0) && dst_valid && dst_en && (src == dst);
  endfunction

endpackage

// File: rtl/control_pipe_hazard_unit.sv
// hazard_unit: combinational RAW check of the incoming control word's read
// sources against the destinations held in EX, MEM and (optionally) WB.
//   rs, rt, live, c_sel, wr_rd : sources/usage of the word on cw_in
//   {ex,mem,wb}_valid/_wb_en/_wb_reg : destination state of each stage
//   hazard : 1 while the incoming word must not be accepted
module hazard_unit
  import cpu_pkg::*;
#(
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       live,
  input  logic       c_sel,
  input  logic       wr_rd,
  input  logic       ex_valid,
  input  logic       ex_wb_en,
  input  logic [4:0] ex_wb_reg,
  input  logic       mem_valid,
  input  logic       mem_wb_en,
  input  logic [4:0] mem_wb_reg,
  input  logic       wb_valid,
  input  logic       wb_wb_en,
  input  logic [4:0] wb_wb_reg,
  output logic       hazard
);

  logic rs_used, rt_used;
  logic ex_hit, mem_hit, wb_hit;

  // rt is the B operand unless the immediate is selected; stores always
  // read rt as the data to write.
  assign rs_used = live;
  assign rt_used = live && (!c_sel || wr_rd);

  assign ex_hit  = reg_hit(rs_used, rs, ex_valid, ex_wb_en, ex_wb_reg)
                || reg_hit(rt_used, rt, ex_valid, ex_wb_en, ex_wb_reg);
  assign mem_hit = reg_hit(rs_used, rs, mem_valid, mem_wb_en, mem_wb_reg)
                || reg_hit(rt_used, rt, mem_valid, mem_wb_en, mem_wb_reg);
  // A write-through register file already returns the WB value on read.
  assign wb_hit  = !WB_BYPASS
                && (reg_hit(rs_used, rs, wb_valid, wb_wb_en, wb_wb_reg)
                 || reg_hit(rt_used, rt, wb_valid, wb_wb_en, wb_wb_reg));

  assign hazard = ex_hit || mem_hit || wb_hit;

endmodule

// File: rtl/control_pipe.sv
// control_pipe: carries decoder control words through EX, MEM and WB,
// stalls the decoder on RAW hazards and holds EX for multi-cycle multiplies.
//   clk, rst            : clock, synchronous active-high reset
//   cw_in/valid/ready   : decoder handshake (ready never depends on valid)
//   ex_*                : EX-stage operand/ALU selects
//   mem_valid/mem_wr_rd : MEM-stage valid and store strobe
//   wb_*                : WB-stage select, write enable and destination
//
// EX FSM
//   state  | meaning
//   EX_RUN | EX advances every cycle; a multiply sitting here starts the hold
//   EX_MUL | EX frozen on a multiply, mul_cnt counts down the remaining hold
module control_pipe
  import cpu_pkg::*;
#(
  parameter int MUL_LAT   = 2,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cw_in,
  input  logic        cw_valid,
  output logic        cw_ready,
  output logic        ex_valid,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic        ex_d_sel,
  output logic        ex_c_sel,
  output logic [1:0]  ex_alu_sel,
  output logic        mem_valid,
  output logic        mem_wr_rd,
  output logic        wb_valid,
  output logic        wb_sel,
  output logic        wb_en,
  output logic [4:0]  wb_reg
);

  localparam bit MUL_STALL = (MUL_LAT > 1);

  ex_state_t  state;
  logic [3:0] mul_cnt;
  ex_stage_t  ex_r;
  mem_stage_t mem_r;
  wb_stage_t  wb_r;
  ex_stage_t  cw_dec;
  logic       live, hazard, ex_hold, accept;
  logic       unused_cw;

  always_comb begin
    cw_dec         = '0;
    cw_dec.rs      = cw_in[CW_RS_HI:CW_RS_LO];
    cw_dec.rt      = cw_in[CW_RT_HI:CW_RT_LO];
    cw_dec.d_sel   = cw_in[CW_DSEL];
    cw_dec.c_sel   = cw_in[CW_CSEL];
    cw_dec.alu_sel = cw_in[CW_ALU_HI:CW_ALU_LO];
    cw_dec.wr_rd   = cw_in[CW_WRRD];
    cw_dec.wb_sel  = cw_in[CW_WBSEL];
    cw_dec.wb_en   = cw_in[CW_WBEN];
    cw_dec.wb_reg  = cw_in[CW_WBREG_HI:CW_WBREG_LO];
  end

  // rd and the top pad bits are not needed by the control path.
  assign unused_cw = ^{cw_in[31:27], cw_in[CW_RD_HI:CW_RD_LO]};

  assign live = cw_in[CW_WBEN] | cw_in[CW_WRRD];

  hazard_unit #(.WB_BYPASS(WB_BYPASS)) u_hazard (
    .rs         (cw_dec.rs),
    .rt         (cw_dec.rt),
    .live       (live),
    .c_sel      (cw_dec.c_sel),
    .wr_rd      (cw_dec.wr_rd),
    .ex_valid   (ex_valid),
    .ex_wb_en   (ex_r.wb_en),
    .ex_wb_reg  (ex_r.wb_reg),
    .mem_valid  (mem_valid),
    .mem_wb_en  (mem_r.wb_en),
    .mem_wb_reg (mem_r.wb_reg),
    .wb_valid   (wb_valid),
    .wb_wb_en   (wb_r.wb_en),
    .wb_wb_reg  (wb_r.wb_reg),
    .hazard     (hazard)
  );

  // The multiply occupies EX for its first cycle in EX_RUN plus MUL_LAT-1
  // cycles in EX_MUL; on the last one (mul_cnt==1) EX advances, so the
  // decoder may hand over the next word on that same edge.
  assign ex_hold = MUL_STALL
                && ((state == EX_RUN && ex_valid && ex_r.d_sel)
                 || (state == EX_MUL && mul_cnt != 4'd1));

  assign cw_ready = !rst && !ex_hold && !hazard;
  assign accept   = cw_valid && cw_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EX_RUN;
      mul_cnt   <= 4'd0;
      ex_valid  <= 1'b0;
      ex_r      <= '0;
      mem_valid <= 1'b0;
      mem_r     <= '0;
      wb_valid  <= 1'b0;
      wb_r      <= '0;
    end else begin
      wb_valid    <= mem_valid;
      wb_r.wb_sel <= mem_r.wb_sel;
      wb_r.wb_en  <= mem_r.wb_en;
      wb_r.wb_reg <= mem_r.wb_reg;

      if (ex_hold) begin
        mem_valid <= 1'b0;
        mem_r     <= '0;
      end else begin
        mem_valid    <= ex_valid;
        mem_r.wr_rd  <= ex_r.wr_rd;
        mem_r.wb_sel <= ex_r.wb_sel;
        mem_r.wb_en  <= ex_r.wb_en;
        mem_r.wb_reg <= ex_r.wb_reg;
        if (accept && live) begin
          ex_valid <= 1'b1;
          ex_r     <= cw_dec;
        end else begin
          ex_valid <= 1'b0;
          ex_r     <= '0;
        end
      end

      case (state)
        EX_RUN: begin
          if (MUL_STALL && ex_valid && ex_r.d_sel) begin
            state   <= EX_MUL;
            mul_cnt <= 4'(MUL_LAT - 1);
          end
        end
        EX_MUL: begin
          if (mul_cnt == 4'd1) begin
            state   <= EX_RUN;
            mul_cnt <= 4'd0;
          end else begin
            mul_cnt <= mul_cnt - 4'd1;
          end
        end
        default: begin
          state   <= EX_RUN;
          mul_cnt <= 4'd0;
        end
      endcase
    end
  end

  assign ex_rs      = ex_r.rs;
  assign ex_rt      = ex_r.rt;
  assign ex_d_sel   = ex_r.d_sel;
  assign ex_c_sel   = ex_r.c_sel;
  assign ex_alu_sel = ex_r.alu_sel;
  assign mem_wr_rd  = mem_valid & mem_r.wr_rd;
  assign wb_sel     = wb_r.wb_sel;
  assign wb_en      = wb_valid & wb_r.wb_en;
  assign wb_reg     = wb_r.wb_reg;

endmodule

// File: tb/tb_control_pipe.sv
// tb_control_pipe: directed bench for control_pipe. Instance a uses the
// write-through register file (WB_BYPASS=1), instance b does not; both
// have MUL_LAT=3.
module tb_control_pipe;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cw_a = '0, cw_b = '0;
  logic        val_a = 1'b0, val_b = 1'b0;

  logic       rdy_a, exv_a, exd_a, exc_a, memv_a, memwr_a, wbv_a, wbs_a, wbe_a;
  logic [4:0] exrs_a, exrt_a, wbr_a;
  logic [1:0] exalu_a;
  logic       rdy_b, exv_b, exd_b, exc_b, memv_b, memwr_b, wbv_b, wbs_b, wbe_b;
  logic [4:0] exrs_b, exrt_b, wbr_b;
  logic [1:0] exalu_b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  control_pipe #(.MUL_LAT(3), .WB_BYPASS(1'b1)) dut_a (
    .clk(clk), .rst(rst), .cw_in(cw_a), .cw_valid(val_a), .cw_ready(rdy_a),
    .ex_valid(exv_a), .ex_rs(exrs_a), .ex_rt(exrt_a), .ex_d_sel(exd_a),
    .ex_c_sel(exc_a), .ex_alu_sel(exalu_a), .mem_valid(memv_a),
    .mem_wr_rd(memwr_a), .wb_valid(wbv_a), .wb_sel(wbs_a), .wb_en(wbe_a),
    .wb_reg(wbr_a)
  );

  control_pipe #(.MUL_LAT(3), .WB_BYPASS(1'b0)) dut_b (
    .clk(clk), .rst(rst), .cw_in(cw_b), .cw_valid(val_b), .cw_ready(rdy_b),
    .ex_valid(exv_b), .ex_rs(exrs_b), .ex_rt(exrt_b), .ex_d_sel(exd_b),
    .ex_c_sel(exc_b), .ex_alu_sel(exalu_b), .mem_valid(memv_b),
    .mem_wr_rd(memwr_b), .wb_valid(wbv_b), .wb_sel(wbs_b), .wb_en(wbe_b),
    .wb_reg(wbr_b)
  );

  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] wreg, input logic d, input logic c,
                                     input logic [1:0] alu, input logic wr,
                                     input logic wsel, input logic wen);
    return {5'b0, rs, rt, 5'd0, d, c, alu, wr, wsel, wen, wreg};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present w until accepted; returns cycles with cw_ready=0 and how many of
  // the resulting EX slots were bubbles. Leaves the caller one cycle after
  // the handshake with cw_valid dropped.
  task automatic issue(input bit sel_b, input logic [31:0] w,
                       output int stalls, output int bubbles);
    bit done = 1'b0;
    logic rdy;
    stalls = 0;
    bubbles = 0;
    if (sel_b) begin cw_b = w; val_b = 1'b1; end
    else       begin cw_a = w; val_a = 1'b1; end
    for (int k = 0; k < 20 && !done; k++) begin
      #1;
      rdy = sel_b ? rdy_b : rdy_a;
      tick();
      if (rdy) done = 1'b1;
      else begin
        stalls++;
        if (!(sel_b ? exv_b : exv_a)) bubbles++;
      end
    end
    val_a = 1'b0; val_b = 1'b0; cw_a = '0; cw_b = '0;
    if (!done) chk_val("issue_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] stream [3];
  logic [4:0]  exp_reg [3];
  logic        exp_sel [3];
  int s, b, nwr, nwbe, nwbv, nrdy0, ndsel, nmemb;
  bit acc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // reset
    tick(); tick();
    chk_val("rst_outs_a", {rdy_a, exv_a, exrs_a, exrt_a, exd_a, exc_a, exalu_a,
                           memv_a, memwr_a, wbv_a, wbs_a, wbe_a, wbr_a}, 32'd0);
    chk_val("rst_outs_b", {rdy_b, exv_b, exrs_b, exrt_b, exd_b, exc_b, exalu_b,
                           memv_b, memwr_b, wbv_b, wbs_b, wbe_b, wbr_b}, 32'd0);
    rst = 1'b0;
    #1;
    chk_val("rst_ready_a", rdy_a, 1);
    chk_val("rst_ready_b", rdy_b, 1);

    // independent stream: add r3, or r6, lw r7
    stream[0] = mk(5'd1, 5'd2, 5'd3, 0, 0, ALU_ADD, 0, 0, 1);
    stream[1] = mk(5'd4, 5'd5, 5'd6, 0, 0, ALU_OR,  0, 0, 1);
    stream[2] = mk(5'd8, 5'd0, 5'd7, 0, 1, ALU_ADD, 0, 1, 1);
    exp_reg[0] = 5'd3; exp_reg[1] = 5'd6; exp_reg[2] = 5'd7;
    exp_sel[0] = 1'b0; exp_sel[1] = 1'b0; exp_sel[2] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) begin
        cw_a = stream[c]; val_a = 1'b1;
        #1;
        chk_val("stream_ready", rdy_a, 1);
      end else begin
        cw_a = '0; val_a = 1'b0;
      end
      tick();
      if (c == 0) begin
        chk_val("ex_lat_valid", exv_a, 1);
        chk_val("ex_lat_rs", exrs_a, 1);
        chk_val("ex_lat_rt", exrt_a, 2);
        chk_val("ex_lat_alu", exalu_a, ALU_ADD);
      end
      if (c == 1) begin
        chk_val("mem_lat_valid", memv_a, 1);
        chk_val("ex_or_alu", exalu_a, ALU_OR);
      end
      if (c >= 2) begin
        chk_val("stream_wb_valid", wbv_a, 1);
        chk_val("stream_wb_reg", wbr_a, exp_reg[c-2]);
        chk_val("stream_wb_sel", wbs_a, exp_sel[c-2]);
        chk_val("stream_wb_en", wbe_a, 1);
      end
    end
    repeat (3) tick();

    // RAW hazard, write-through register file
    issue(0, mk(5'd1, 5'd2, 5'd3, 0, 0, ALU_ADD, 0, 0, 1), s, b);
    chk_val("raw_a_first", s, 0);
    issue(0, mk(5'd3, 5'd1, 5'd4, 0, 0, ALU_SUB, 0, 0, 1), s, b);
    chk_val("raw_a_stalls", s, 2);
    chk_val("raw_a_bubbles", b, 2);
    chk_val("raw_a_ex_rs", exrs_a, 3);
    chk_val("raw_a_ex_alu", exalu_a, ALU_SUB);

    // RAW hazard, no bypass
    issue(1, mk(5'd1, 5'd2, 5'd3, 0, 0, ALU_ADD, 0, 0, 1), s, b);
    issue(1, mk(5'd3, 5'd1, 5'd4, 0, 0, ALU_SUB, 0, 0, 1), s, b);
    chk_val("raw_b_stalls", s, 3);
    chk_val("raw_b_bubbles", b, 3);
    repeat (3) tick();

    // r0 destination never stalls
    issue(0, mk(5'd1, 5'd2, 5'd0, 0, 0, ALU_ADD, 0, 0, 1), s, b);
    issue(0, mk(5'd0, 5'd0, 5'd5, 0, 0, ALU_ADD, 0, 0, 1), s, b);
    chk_val("r0_stalls", s, 0);
    repeat (3) tick();

    // store after load
    issue(0, mk(5'd8, 5'd0, 5'd5, 0, 1, ALU_ADD, 0, 1, 1), s, b);
    issue(0, mk(5'd9, 5'd5, 5'd0, 0, 1, ALU_ADD, 1, 0, 0), s, b);
    chk_val("sw_stalls", s, 2);
    nwr = 0; nwbe = 0; nwbv = 0;
    for (int k = 0; k < 6; k++) begin
      if (memwr_a) nwr++;
      if (wbe_a) nwbe++;
      if (wbv_a) nwbv++;
      tick();
    end
    chk_val("sw_wr_cycles", nwr, 1);
    chk_val("sw_wb_en", nwbe, 0);
    chk_val("sw_wb_valid", nwbv, 1);

    // multiply hold, MUL_LAT=3
    issue(0, mk(5'd1, 5'd2, 5'd11, 0, 0, ALU_ADD, 0, 0, 1), s, b);
    issue(0, mk(5'd1, 5'd2, 5'd9, 1, 0, ALU_ADD, 0, 0, 1), s, b);
    chk_val("mul_issue_stalls", s, 0);
    cw_a = mk(5'd3, 5'd4, 5'd10, 0, 0, ALU_ADD, 0, 0, 1); val_a = 1'b1;
    acc = 1'b0; nrdy0 = 0; ndsel = 0; nmemb = 0;
    for (int k = 0; k < 8 && !acc; k++) begin
      #1;
      if (exd_a) ndsel++;
      if (!memv_a) nmemb++;
      if (rdy_a) acc = 1'b1; else nrdy0++;
      tick();
    end
    val_a = 1'b0; cw_a = '0;
    chk_val("mul_accepted", acc, 1);
    chk_val("mul_ready_low", nrdy0, 2);
    chk_val("mul_dsel_cycles", ndsel, 3);
    chk_val("mul_mem_bubbles", nmemb, 2);
    chk_val("mul_next_ex_dsel", exd_a, 0);
    chk_val("mul_next_ex_rs", exrs_a, 3);
    chk_val("mul_in_mem", memv_a, 1);
    tick();
    chk_val("mul_wb_reg", wbr_a, 9);
    tick();
    chk_val("mul_add_wb_reg", wbr_a, 10);
    repeat (3) tick();

    // reset in the middle of a multiply
    issue(0, mk(5'd1, 5'd2, 5'd9, 1, 0, ALU_ADD, 0, 0, 1), s, b);
    tick();
    rst = 1'b1;
    tick();
    chk_val("rst_mul_valids", {exv_a, memv_a, wbv_a}, 0);
    rst = 1'b0;
    #1;
    chk_val("rst_mul_ready", rdy_a, 1);
    issue(0, mk(5'd3, 5'd4, 5'd10, 0, 0, ALU_ADD, 0, 0, 1), s, b);
    chk_val("rst_fresh_stalls", s, 0);
    chk_val("rst_fresh_ex", {exv_a, exrs_a}, {1'b1, 5'd3});
    tick();
    chk_val("rst_fresh_adv", {exv_a, memv_a}, {1'b0, 1'b1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
